temporizador_regresivo: RTL and testbench
=========================================

# temporizador_regresivo

BCD countdown timer that produces the timer-value registers HRTC/MRTC/SRTC and the `alarma_on` arm flag consumed by the ring indicator. The user loads HH:MM:SS, starts, pauses or aborts the count. The block decrements once per 1 Hz strobe, holds at 00:00:00 on expiry, and stays expired until the alarm is acknowledged. It sits between the user-input/debounce logic and the ring indicator.

## Interface
- `HORA_MAX`, default 8'h23: maximum accepted hours value, in BCD.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-low reset.
- `tick_1hz`  in  1: one-cycle strobe, once per second.
- `cargar`  in  1: load pulse. Captures `h_in`/`m_in`/`s_in`.
- `iniciar`  in  1: start/resume pulse.
- `detener`  in  1: pause pulse.
- `apagar_alarma`  in  1: acknowledge in EXPIRED; abort in RUN or PAUSE.
- `h_in`, `m_in`, `s_in`  in  8 each: BCD load value, {tens, units}.
- `HRTC`, `MRTC`, `SRTC`  out  8 each: current BCD count, registered.
- `alarma_on`  out  1: high in RUN, PAUSE and EXPIRED.
- `fin`  out  1: one-cycle pulse on expiry.
- `err_carga`  out  1: one-cycle pulse when a load is rejected.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- **IDLE**
  - `cargar` with a valid value: count takes the value.
  - `iniciar` with a non-zero count: go to RUN.
  - `iniciar` with a zero count: ignored, stay in IDLE.
- **RUN**
  - `tick_1hz`: decrement the count.
  - `detener`: go to PAUSE.
  - `apagar_alarma`: go to IDLE, count retained.
  - `cargar`: ignored.
- **PAUSE**
  - `iniciar`: go to RUN.
  - `cargar` with a valid value: count takes the value, stay in PAUSE.
  - `apagar_alarma`: go to IDLE.
  - `tick_1hz`: ignored.
- **EXPIRED**
  - Count is held at 00:00:00.
  - `apagar_alarma`: go to IDLE.
  - All other inputs are ignored.
- **Load validity.** A load is valid only if all of these hold:
  - every nibble is ≤ 9;
  - `m_in` and `s_in` tens digits are ≤ 5;
  - `h_in` ≤ `HORA_MAX`, compared as BCD.
- **Rejected load.** Count is unchanged and `err_carga` pulses. A load attempted in RUN or EXPIRED is ignored silently, with no `err_carga`.
- **Decrement** (BCD, digit-wise with borrow):
  - Seconds units: 0 becomes 9 and borrows from the tens.
  - Seconds tens: 0 becomes 5 and borrows from minutes units.
  - Minutes follow the same rule: units 0→9, tens 0→5, borrowing from hours units.
  - Hours units: 0 becomes 9 and borrows from hours tens.
  - Hours never underflow, because the count stops at zero.
- **Expiry.** If a decrement produces 00:00:00, the state becomes EXPIRED on the same edge.
- **Priority within RUN, same cycle:** `apagar_alarma` > `detener` > `tick_1hz`.
  - `detener` together with `tick_1hz`: pause, no decrement.
- **Priority within PAUSE, same cycle:** `apagar_alarma` > `iniciar` > `cargar`.
- **Priority within IDLE, same cycle:** `cargar` is applied first. `iniciar` then tests the newly loaded value, so load+start in one cycle starts if the loaded value is non-zero.

## Timing
- **Reset** (`reset`=0 at a rising edge): state IDLE; `HRTC`=`MRTC`=`SRTC`=8'h00; `alarma_on`=0; `fin`=0; `err_carga`=0. Reset wins over every other input, in any state.
- **Load latency:** `cargar` sampled at edge n; the count is visible at n+1.
- **Decrement latency:** `tick_1hz` sampled at edge n; the new count is visible at n+1.
- **Expiry:** the last tick is sampled at edge n. At n+1 the count is 00:00:00, the state is EXPIRED, and `fin`=1 for exactly that one cycle.
- **`alarma_on` rises** at the edge that enters RUN and stays high through PAUSE and EXPIRED.
- **`alarma_on` falls** at the edge that enters IDLE.
- **`err_carga`:** high for exactly the cycle after the rejected `cargar`.
- Pulses held high for multiple cycles are evaluated every cycle. They are level-safe because each state ignores repeats.

## Test plan
1. **Reset.** Drive `reset`=0 mid-RUN at count 00:00:30 → next cycle all outputs are 0 and state is IDLE.
2. **Load and run.** Load 00:01:00, `iniciar`, 1 tick → 00:00:59. 59 more ticks → 00:00:00, `fin` high one cycle, `alarma_on`=1. `apagar_alarma` → `alarma_on`=0.
3. **Borrow chain.** Load 10:00:00, 1 tick → 09:59:59. Load 23:59:59, 1 tick → 23:59:58.
4. **Invalid loads.** Load 8'h24/00/00, 8'h00/8'h60/00 and 8'h0A/00/00 → `err_carga` pulses each time, count unchanged. Start with count zero → stays IDLE, `alarma_on`=0.
5. **Simultaneous events.** `detener` and `tick_1hz` in the same cycle at 00:00:05 → PAUSE, count 00:00:05. Ticks in PAUSE → no change. `iniciar` → RUN, next tick → 00:00:04.
6. **Abort and reload.** `apagar_alarma` in RUN at 00:00:10 → IDLE, count 00:00:10, `alarma_on`=0. Load 00:00:01 with `iniciar` in the same cycle → RUN. 1 tick → EXPIRED, `fin` pulses.

Source files
------------

// File: rtl/temporizador_regresivo.sv
// BCD HH:MM:SS countdown timer with load/start/pause/abort and an expiry alarm flag.
// All outputs registered, one cycle after the sampled input; no backpressure, repeated pulses are ignored.
module temporizador_regresivo #(
    parameter logic [7:0] HORA_MAX = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       cargar,
    input  logic       iniciar,
    input  logic       detener,
    input  logic       apagar_alarma,
    input  logic [7:0] h_in,
    input  logic [7:0] m_in,
    input  logic [7:0] s_in,
    output logic [7:0] HRTC,
    output logic [7:0] MRTC,
    output logic [7:0] SRTC,
    output logic       alarma_on,
    output logic       fin,
    output logic       err_carga
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_h;
    logic [7:0] r_m;
    logic [7:0] r_s;
    logic       r_alarma;
    logic       r_fin;
    logic       r_err;

    logic [7:0] w_h_nxt;
    logic [7:0] w_m_nxt;
    logic [7:0] w_s_nxt;
    logic       w_fin_nxt;
    logic       w_err_nxt;

    logic       w_load_ok;
    logic       w_load_zero;
    logic       w_cnt_zero;

    logic [3:0] w_s_u;
    logic [3:0] w_s_t;
    logic [3:0] w_m_u;
    logic [3:0] w_m_t;
    logic [3:0] w_h_u;
    logic [3:0] w_h_t;
    logic       w_b0;
    logic       w_b1;
    logic       w_b2;
    logic       w_b3;
    logic       w_b4;
    logic [7:0] w_dec_h;
    logic [7:0] w_dec_m;
    logic [7:0] w_dec_s;
    logic       w_dec_zero;

    // Once every nibble is a decimal digit, a plain binary compare orders BCD hours correctly.
    assign w_load_ok = (h_in[3:0] <= 4'd9) && (h_in[7:4] <= 4'd9) &&
                       (m_in[3:0] <= 4'd9) && (m_in[7:4] <= 4'd5) &&
                       (s_in[3:0] <= 4'd9) && (s_in[7:4] <= 4'd5) &&
                       (h_in <= HORA_MAX);
    assign w_load_zero = ({h_in, m_in, s_in} == 24'h000000);
    assign w_cnt_zero  = ({r_h, r_m, r_s} == 24'h000000);

    // Digit-wise borrow chain: each digit wraps to its maximum when it borrows from zero.
    assign w_b0  = (r_s[3:0] == 4'd0);
    assign w_s_u = w_b0 ? 4'd9 : r_s[3:0] - 4'd1;
    assign w_b1  = w_b0 && (r_s[7:4] == 4'd0);
    assign w_s_t = !w_b0 ? r_s[7:4] : (w_b1 ? 4'd5 : r_s[7:4] - 4'd1);
    assign w_b2  = w_b1 && (r_m[3:0] == 4'd0);
    assign w_m_u = !w_b1 ? r_m[3:0] : (w_b2 ? 4'd9 : r_m[3:0] - 4'd1);
    assign w_b3  = w_b2 && (r_m[7:4] == 4'd0);
    assign w_m_t = !w_b2 ? r_m[7:4] : (w_b3 ? 4'd5 : r_m[7:4] - 4'd1);
    assign w_b4  = w_b3 && (r_h[3:0] == 4'd0);
    assign w_h_u = !w_b3 ? r_h[3:0] : (w_b4 ? 4'd9 : r_h[3:0] - 4'd1);
    assign w_h_t = !w_b4 ? r_h[7:4] : r_h[7:4] - 4'd1;

    assign w_dec_h    = {w_h_t, w_h_u};
    assign w_dec_m    = {w_m_t, w_m_u};
    assign w_dec_s    = {w_s_t, w_s_u};
    assign w_dec_zero = ({w_dec_h, w_dec_m, w_dec_s} == 24'h000000);

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_m_nxt     = r_m;
        w_s_nxt     = r_s;
        w_fin_nxt   = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cargar) begin
                    if (w_load_ok) begin
                        w_h_nxt = h_in;
                        w_m_nxt = m_in;
                        w_s_nxt = s_in;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                // Start tests the value this cycle will hold, so load+start works in one pulse.
                if (iniciar) begin
                    if ((cargar && w_load_ok) ? !w_load_zero : !w_cnt_zero) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (apagar_alarma) begin
                    w_state_nxt = S_IDLE;
                end else if (detener) begin
                    w_state_nxt = S_PAUSE;
                end else if (tick_1hz) begin
                    // A zero count can reach RUN via a zero load in PAUSE; expire rather than underflow.
                    if (w_cnt_zero || w_dec_zero) begin
                        w_h_nxt     = 8'h00;
                        w_m_nxt     = 8'h00;
                        w_s_nxt     = 8'h00;
                        w_state_nxt = S_EXPIRED;
                        w_fin_nxt   = 1'b1;
                    end else begin
                        w_h_nxt = w_dec_h;
                        w_m_nxt = w_dec_m;
                        w_s_nxt = w_dec_s;
                    end
                end
            end

            S_PAUSE: begin
                if (apagar_alarma) begin
                    w_state_nxt = S_IDLE;
                end else if (iniciar) begin
                    w_state_nxt = S_RUN;
                end else if (cargar) begin
                    if (w_load_ok) begin
                        w_h_nxt = h_in;
                        w_m_nxt = m_in;
                        w_s_nxt = s_in;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_EXPIRED: begin
                w_h_nxt = 8'h00;
                w_m_nxt = 8'h00;
                w_s_nxt = 8'h00;
                if (apagar_alarma) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_h      <= 8'h00;
            r_m      <= 8'h00;
            r_s      <= 8'h00;
            r_alarma <= 1'b0;
            r_fin    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_h      <= w_h_nxt;
            r_m      <= w_m_nxt;
            r_s      <= w_s_nxt;
            r_alarma <= (w_state_nxt != S_IDLE);
            r_fin    <= w_fin_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign HRTC      = r_h;
    assign MRTC      = r_m;
    assign SRTC      = r_s;
    assign alarma_on = r_alarma;
    assign fin       = r_fin;
    assign err_carga = r_err;

endmodule

// File: tb/tb_temporizador_regresivo.sv
// Directed bench for temporizador_regresivo: cycle-by-cycle vector table plus a full one-minute countdown.
module tb_temporizador_regresivo;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       cargar;
    logic       iniciar;
    logic       detener;
    logic       apagar_alarma;
    logic [7:0] h_in;
    logic [7:0] m_in;
    logic [7:0] s_in;
    logic [7:0] HRTC;
    logic [7:0] MRTC;
    logic [7:0] SRTC;
    logic       alarma_on;
    logic       fin;
    logic       err_carga;

    int n_checks;
    int n_fails;

    // Control word: {reset_n, tick, cargar, iniciar, detener, apagar}
    localparam logic [5:0] C_NONE = 6'b100000;
    localparam logic [5:0] C_TICK = 6'b010000;
    localparam logic [5:0] C_LOAD = 6'b001000;
    localparam logic [5:0] C_INI  = 6'b000100;
    localparam logic [5:0] C_DET  = 6'b000010;
    localparam logic [5:0] C_APA  = 6'b000001;

    typedef struct {
        string      name;
        logic [5:0] cmd;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [7:0] eh;
        logic [7:0] em;
        logic [7:0] es;
        logic       eal;
        logic       efin;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    temporizador_regresivo #(.HORA_MAX(8'h23)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_1hz      (tick_1hz),
        .cargar        (cargar),
        .iniciar       (iniciar),
        .detener       (detener),
        .apagar_alarma (apagar_alarma),
        .h_in          (h_in),
        .m_in          (m_in),
        .s_in          (s_in),
        .HRTC          (HRTC),
        .MRTC          (MRTC),
        .SRTC          (SRTC),
        .alarma_on     (alarma_on),
        .fin           (fin),
        .err_carga     (err_carga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [5:0] c,
                                input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                                input logic al, input logic f, input logic e);
        vec_t v;
        v.name = n; v.cmd = c; v.h = h; v.m = m; v.s = s;
        v.eh = eh; v.em = em; v.es = es; v.eal = al; v.efin = f; v.eerr = e;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int k);
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point after the next edge.
    task automatic step(input logic [5:0] cmd, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        reset         = cmd[5];
        tick_1hz      = cmd[4];
        cargar        = cmd[3];
        iniciar       = cmd[2];
        detener       = cmd[1];
        apagar_alarma = cmd[0];
        h_in = h; m_in = m; s_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                         input logic eal, input logic efin, input logic eerr);
        logic [26:0] act;
        logic [26:0] exp_v;
        act   = {HRTC, MRTC, SRTC, alarma_on, fin, err_carga};
        exp_v = {eh, em, es, eal, efin, eerr};
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h:%h:%h al=%b fin=%b err=%b, want %h:%h:%h al=%b fin=%b err=%b",
                     name, HRTC, MRTC, SRTC, alarma_on, fin, err_carga, eh, em, es, eal, efin, eerr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0; tick_1hz = 1'b0; cargar = 1'b0; iniciar = 1'b0;
        detener = 1'b0; apagar_alarma = 1'b0; h_in = 8'h00; m_in = 8'h00; s_in = 8'h00;

        vecs.push_back(mk("reset",        6'b000000,        8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("idle",         C_NONE,           8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("start_zero",   C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("bad_h24",      C_NONE|C_LOAD,    8'h24,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,1));
        vecs.push_back(mk("err_clear",    C_NONE,           8'h24,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("bad_m60",      C_NONE|C_LOAD,    8'h00,8'h60,8'h00, 8'h00,8'h00,8'h00, 0,0,1));
        vecs.push_back(mk("bad_h0a",      C_NONE|C_LOAD,    8'h0A,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,1));
        vecs.push_back(mk("bad_s5a_ini",  C_NONE|C_LOAD|C_INI, 8'h00,8'h00,8'h5A, 8'h00,8'h00,8'h00, 0,0,1));
        vecs.push_back(mk("load_max",     C_NONE|C_LOAD,    8'h23,8'h59,8'h59, 8'h23,8'h59,8'h59, 0,0,0));
        vecs.push_back(mk("run_max",      C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h23,8'h59,8'h59, 1,0,0));
        vecs.push_back(mk("tick_max",     C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h23,8'h59,8'h58, 1,0,0));
        vecs.push_back(mk("load_in_run",  C_NONE|C_LOAD,    8'h00,8'h00,8'h05, 8'h23,8'h59,8'h58, 1,0,0));
        vecs.push_back(mk("bad_in_run",   C_NONE|C_LOAD,    8'h99,8'h99,8'h99, 8'h23,8'h59,8'h58, 1,0,0));
        vecs.push_back(mk("abort_max",    C_NONE|C_APA,     8'h00,8'h00,8'h00, 8'h23,8'h59,8'h58, 0,0,0));
        vecs.push_back(mk("load_10h",     C_NONE|C_LOAD,    8'h10,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("run_10h",      C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 1,0,0));
        vecs.push_back(mk("borrow_chain", C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h09,8'h59,8'h59, 1,0,0));
        vecs.push_back(mk("abort_tick",   C_NONE|C_APA|C_TICK, 8'h00,8'h00,8'h00, 8'h09,8'h59,8'h59, 0,0,0));
        vecs.push_back(mk("load_5s",      C_NONE|C_LOAD,    8'h00,8'h00,8'h05, 8'h00,8'h00,8'h05, 0,0,0));
        vecs.push_back(mk("run_5s",       C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h05, 1,0,0));
        vecs.push_back(mk("det_tick",     C_NONE|C_DET|C_TICK, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h05, 1,0,0));
        vecs.push_back(mk("tick_pause1",  C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h00,8'h00,8'h05, 1,0,0));
        vecs.push_back(mk("tick_pause2",  C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h00,8'h00,8'h05, 1,0,0));
        vecs.push_back(mk("bad_in_pause", C_NONE|C_LOAD,    8'h00,8'h00,8'h6A, 8'h00,8'h00,8'h05, 1,0,1));
        vecs.push_back(mk("ini_over_ld",  C_NONE|C_INI|C_LOAD, 8'h00,8'h00,8'h09, 8'h00,8'h00,8'h05, 1,0,0));
        vecs.push_back(mk("tick_resume",  C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h00,8'h00,8'h04, 1,0,0));
        vecs.push_back(mk("pause_again",  C_NONE|C_DET,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h04, 1,0,0));
        vecs.push_back(mk("load_pause",   C_NONE|C_LOAD,    8'h00,8'h00,8'h10, 8'h00,8'h00,8'h10, 1,0,0));
        vecs.push_back(mk("abort_pause",  C_NONE|C_APA,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h10, 0,0,0));
        vecs.push_back(mk("load_go",      C_NONE|C_LOAD|C_INI, 8'h00,8'h00,8'h01, 8'h00,8'h00,8'h01, 1,0,0));
        vecs.push_back(mk("expire",       C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 1,1,0));
        vecs.push_back(mk("exp_hold",     C_NONE|C_TICK,    8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 1,0,0));
        vecs.push_back(mk("exp_ignore",   C_NONE|C_LOAD|C_INI|C_DET, 8'h00,8'h00,8'h05, 8'h00,8'h00,8'h00, 1,0,0));
        vecs.push_back(mk("exp_bad_ld",   C_NONE|C_LOAD,    8'hFF,8'hFF,8'hFF, 8'h00,8'h00,8'h00, 1,0,0));
        vecs.push_back(mk("ack",          C_NONE|C_APA,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("load_30",      C_NONE|C_LOAD,    8'h00,8'h00,8'h30, 8'h00,8'h00,8'h30, 0,0,0));
        vecs.push_back(mk("run_30",       C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h30, 1,0,0));
        vecs.push_back(mk("reset_in_run", C_TICK,           8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));
        vecs.push_back(mk("post_reset",   C_NONE|C_INI,     8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cmd, vecs[i].h, vecs[i].m, vecs[i].s);
            check(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es,
                  vecs[i].eal, vecs[i].efin, vecs[i].eerr);
        end

        // Full one-minute countdown: every intermediate second, then the single fin pulse.
        step(C_NONE|C_LOAD, 8'h00, 8'h01, 8'h00);
        check("min_load", 8'h00, 8'h01, 8'h00, 0, 0, 0);
        step(C_NONE|C_INI, 8'h00, 8'h00, 8'h00);
        check("min_run", 8'h00, 8'h01, 8'h00, 1, 0, 0);
        for (int k = 59; k >= 1; k--) begin
            step(C_NONE|C_TICK, 8'h00, 8'h00, 8'h00);
            check($sformatf("min_tick_%0d", k), 8'h00, 8'h00, to_bcd(k), 1, 0, 0);
            step(C_NONE, 8'h00, 8'h00, 8'h00);
            check($sformatf("min_gap_%0d", k), 8'h00, 8'h00, to_bcd(k), 1, 0, 0);
        end
        step(C_NONE|C_TICK, 8'h00, 8'h00, 8'h00);
        check("min_expire", 8'h00, 8'h00, 8'h00, 1, 1, 0);
        step(C_NONE, 8'h00, 8'h00, 8'h00);
        check("min_fin_once", 8'h00, 8'h00, 8'h00, 1, 0, 0);
        step(C_NONE|C_APA, 8'h00, 8'h00, 8'h00);
        check("min_ack", 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // Held detener over several ticks must pause exactly once and never decrement.
        step(C_NONE|C_LOAD|C_INI, 8'h01, 8'h00, 8'h00);
        check("hold_go", 8'h01, 8'h00, 8'h00, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(C_NONE|C_DET|C_TICK, 8'h00, 8'h00, 8'h00);
            check($sformatf("hold_det_%0d", k), 8'h01, 8'h00, 8'h00, 1, 0, 0);
        end
        step(C_NONE|C_INI, 8'h00, 8'h00, 8'h00);
        step(C_NONE|C_TICK, 8'h00, 8'h00, 8'h00);
        check("hold_resume_tick", 8'h00, 8'h59, 8'h59, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
